// File: rtl/exe_mem_stall_ctrl_pkg.sv
// Shared types and constants for the EXE-stage memory access sequencer.
package exe_mem_stall_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned CTRL_W     = 16;
  localparam int unsigned DST_W      = 5;
  localparam int unsigned MEM_OP_BIT = 2;
  localparam int unsigned LOAD_BIT   = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4,
    S_FAULT = 3'd5
  } state_e;

  // States in which an access is outstanding on the memory port.
  function automatic logic is_busy(input state_e s);
    return (s == S_REQ) || (s == S_WAIT) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/exe_mem_stall_ctrl_mem_timeout_ctr.sv
// Saturating cycle counter that flags when an outstanding access has used up its budget.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expires on the cycle that would make the count reach TIMEOUT.
  assign expired_c = enable && (cnt_q >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/exe_mem_stall_ctrl.sv
// Holds a load/store in EXE against a valid/ready memory port, freezing IF..EXE until it
// completes, then hands load data to WB or reports an access fault.
module exe_mem_stall_ctrl
  import exe_mem_stall_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EXE_VALID,
  input  logic [CTRL_W-1:0] EXE_Control_Signal,
  input  logic [DATA_W-1:0] EXE_ADDR,
  input  logic [DATA_W-1:0] EXE_STORE_DATA,
  input  logic [DST_W-1:0]  EXE_DST_FIELD,
  input  logic              FLUSH,
  output logic              MEM_REQ_VALID,
  input  logic              MEM_REQ_READY,
  output logic [DATA_W-1:0] MEM_REQ_ADDR,
  output logic [DATA_W-1:0] MEM_REQ_WDATA,
  output logic              MEM_REQ_WE,
  input  logic              MEM_RSP_VALID,
  input  logic [DATA_W-1:0] MEM_RSP_DATA,
  input  logic              MEM_RSP_ERR,
  output logic              STALL_PIPELINE,
  output logic              WB_VALID,
  output logic [DST_W-1:0]  WB_DST,
  output logic [DATA_W-1:0] WB_DATA,
  output logic              EXC_VALID,
  output logic              EXC_IS_STORE
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DST_W-1:0]  dst_q, dst_d;
  logic              we_q, we_d;
  logic              flushed_q, flushed_d;

  logic mem_op_c;
  logic tmo_clear_c;
  logic tmo_en_c;
  logic tmo_expired_c;
  logic unused_ctrl_c;

  assign unused_ctrl_c = ^{EXE_Control_Signal[CTRL_W-1:LOAD_BIT+1],
                           EXE_Control_Signal[MEM_OP_BIT-1:0]};

  assign mem_op_c    = EXE_VALID && EXE_Control_Signal[MEM_OP_BIT] && !FLUSH;
  assign tmo_en_c    = is_busy(state_q);
  assign tmo_clear_c = (state_d == S_IDLE);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (CLK),
    .rst       (RST),
    .clear     (tmo_clear_c),
    .enable    (tmo_en_c),
    .expired_c (tmo_expired_c)
  );

  // Next-state and capture logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    dst_d     = dst_q;
    we_d      = we_q;
    flushed_d = flushed_q;

    unique case (state_q)
      S_IDLE: begin
        flushed_d = 1'b0;
        if (mem_op_c) begin
          addr_d  = EXE_ADDR;
          wdata_d = EXE_STORE_DATA;
          dst_d   = EXE_DST_FIELD;
          we_d    = !EXE_Control_Signal[LOAD_BIT];
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // A request already on the bus is never withdrawn; a flush only redirects its response.
        if (FLUSH) flushed_d = 1'b1;
        if (MEM_REQ_READY) begin
          state_d = (flushed_q || FLUSH) ? S_DRAIN : S_WAIT;
        end else if (tmo_expired_c) begin
          state_d = (flushed_q || FLUSH) ? S_IDLE : S_FAULT;
        end
      end
      S_WAIT: begin
        if (FLUSH) begin
          state_d = (MEM_RSP_VALID || tmo_expired_c) ? S_IDLE : S_DRAIN;
        end else if (MEM_RSP_VALID) begin
          if (MEM_RSP_ERR) begin
            state_d = S_FAULT;
          end else begin
            rdata_d = MEM_RSP_DATA;
            state_d = S_DONE;
          end
        end else if (tmo_expired_c) begin
          state_d = S_FAULT;
        end
      end
      S_DRAIN: begin
        if (MEM_RSP_VALID || tmo_expired_c) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      dst_q     <= '0;
      we_q      <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      dst_q     <= dst_d;
      we_q      <= we_d;
      flushed_q <= flushed_d;
    end
  end

  // Stall rises in the detect cycle so the op stays in EXE while it is captured.
  assign STALL_PIPELINE = ((state_q == S_IDLE) && mem_op_c) || is_busy(state_q);

  assign MEM_REQ_VALID = (state_q == S_REQ);
  assign MEM_REQ_ADDR  = addr_q;
  assign MEM_REQ_WDATA = wdata_q;
  assign MEM_REQ_WE    = we_q;

  assign WB_VALID     = (state_q == S_DONE) && !we_q && !FLUSH;
  assign WB_DST       = dst_q;
  assign WB_DATA      = rdata_q;
  assign EXC_VALID    = (state_q == S_FAULT) && !FLUSH;
  assign EXC_IS_STORE = EXC_VALID && we_q;

endmodule

// File: tb/tb_exe_mem_stall_ctrl.sv
// Randomized bench for exe_mem_stall_ctrl: a reactive memory/pipeline model records what the
// DUT does per transaction, and each scenario compares that against transaction-level timing.
module tb_exe_mem_stall_ctrl;

  localparam int TMO = 8;

  logic        clk, rst, exe_valid, flush;
  logic [15:0] ctrl;
  logic [63:0] exe_addr, exe_wdata;
  logic [4:0]  exe_dst;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [63:0] mem_rsp_data;
  logic        stall, wb_valid, exc_valid, exc_is_store;
  logic [4:0]  wb_dst;
  logic [63:0] wb_data;

  int checks = 0;
  int failures = 0;

  int          obs_stall_cnt, obs_valid_cnt, obs_req_bad, obs_wb_cnt, obs_exc_cnt;
  int          obs_res_cyc, obs_exc_cyc;
  bit          obs_done, obs_post_rst_bad, obs_exc_store;
  logic [4:0]  obs_wb_dst;
  logic [63:0] obs_wb_data;

  exe_mem_stall_ctrl #(.DATA_W(64), .TIMEOUT(TMO)) dut (
    .CLK(clk), .RST(rst), .EXE_VALID(exe_valid), .EXE_Control_Signal(ctrl),
    .EXE_ADDR(exe_addr), .EXE_STORE_DATA(exe_wdata), .EXE_DST_FIELD(exe_dst), .FLUSH(flush),
    .MEM_REQ_VALID(mem_req_valid), .MEM_REQ_READY(mem_req_ready), .MEM_REQ_ADDR(mem_req_addr),
    .MEM_REQ_WDATA(mem_req_wdata), .MEM_REQ_WE(mem_req_we), .MEM_RSP_VALID(mem_rsp_valid),
    .MEM_RSP_DATA(mem_rsp_data), .MEM_RSP_ERR(mem_rsp_err), .STALL_PIPELINE(stall),
    .WB_VALID(wb_valid), .WB_DST(wb_dst), .WB_DATA(wb_data), .EXC_VALID(exc_valid),
    .EXC_IS_STORE(exc_is_store)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One memory op through a pipeline that holds EXE while stalled and a memory that raises
  // READY after r VALID cycles and responds d cycles after the handshake (d<0: never).
  task automatic drive_txn(input bit load, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [4:0] dst, input int r, input int d, input bit err,
                           input logic [63:0] rdata, input int flush_cyc, input int rst_cyc,
                           input int stray_cyc, input int tail);
    int req_cnt;
    int rsp_due;
    bit prev_stall;
    bit killed;
    bit seen_stall;
    req_cnt = 0; rsp_due = -1; prev_stall = 0; killed = 0; seen_stall = 0;
    obs_stall_cnt = 0; obs_valid_cnt = 0; obs_req_bad = 0; obs_wb_cnt = 0; obs_exc_cnt = 0;
    obs_res_cyc = -1; obs_exc_cyc = -1; obs_done = 0; obs_post_rst_bad = 0;
    obs_exc_store = 0; obs_wb_dst = '0; obs_wb_data = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == flush_cyc || c == rst_cyc) killed = 1;
      rst       = (c == rst_cyc);
      flush     = (c == flush_cyc);
      exe_valid = (c == 0 || prev_stall) && !killed;
      ctrl      = '0;
      ctrl[2]   = 1'b1;
      ctrl[3]   = load;
      exe_addr  = addr;
      exe_wdata = wdata;
      exe_dst   = dst;
      mem_req_ready = mem_req_valid && (req_cnt == r) && !rst;
      if (mem_req_valid) begin
        req_cnt++;
        if (mem_req_ready && d >= 0) rsp_due = c + d;
      end
      if (c == rst_cyc) rsp_due = -1;
      mem_rsp_valid = (c == rsp_due) || (c == stray_cyc);
      mem_rsp_err   = err && (c == rsp_due);
      mem_rsp_data  = (c == rsp_due) ? rdata : 64'h5A5A_5A5A_0000_FFFF;
      #1;
      if (rst_cyc >= 0 && c == rst_cyc + 1 &&
          (stall || mem_req_valid || wb_valid || exc_valid || exc_is_store))
        obs_post_rst_bad = 1;
      if (mem_req_valid) begin
        obs_valid_cnt++;
        if (mem_req_addr !== addr || mem_req_wdata !== wdata || mem_req_we !== !load)
          obs_req_bad++;
      end
      if (wb_valid) begin
        obs_wb_cnt++;
        obs_wb_dst  = wb_dst;
        obs_wb_data = wb_data;
      end
      if (exc_valid) begin
        obs_exc_cnt++;
        obs_exc_store = exc_is_store;
        if (obs_exc_cyc < 0) obs_exc_cyc = c;
      end
      if (stall) begin
        obs_stall_cnt++;
        seen_stall = 1;
      end else if (seen_stall && obs_res_cyc < 0) begin
        obs_res_cyc = c;
      end
      prev_stall = stall;
      if (obs_res_cyc >= 0 && c >= obs_res_cyc + tail) begin
        obs_done = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; exe_valid = 0; flush = 0; ctrl = '0; exe_addr = '0; exe_wdata = '0; exe_dst = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_err = 0; mem_rsp_data = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if ({stall, mem_req_valid, mem_req_we, wb_valid, exc_valid, exc_is_store} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {stall, mem_req_valid, mem_req_we, wb_valid, exc_valid, exc_is_store});
    end
    checks++;
    if ({mem_req_addr, mem_req_wdata, wb_data, wb_dst} !== '0) begin
      failures++;
      $display("FAIL reset_data: addr=%h wdata=%h wb_data=%h wb_dst=%0d want all 0",
               mem_req_addr, mem_req_wdata, wb_data, wb_dst);
    end
  endtask

  task automatic test_non_mem();
    @(negedge clk);
    exe_valid = 1; ctrl = 16'hFFF3;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL non_mem_stall: got %b want 0", stall);
    end
    @(negedge clk);
    exe_valid = 0;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL non_mem_req: got %b want 0", mem_req_valid);
    end
  endtask

  task automatic test_load_basic();
    drive_txn(1, {$urandom, $urandom}, {$urandom, $urandom}, 5'd5, 0, 1, 0,
              64'h0000_0000_DEAD_BEEF, -1, -1, -1, 0);
    checks++;
    if (!obs_done || obs_stall_cnt != 3 || obs_res_cyc != 3) begin
      failures++;
      $display("FAIL load_stall: done=%0d stall_cycles=%0d result_cycle=%0d want 1/3/3",
               obs_done, obs_stall_cnt, obs_res_cyc);
    end
    checks++;
    if (obs_wb_cnt != 1 || obs_wb_dst !== 5'd5 || obs_wb_data !== 64'hDEAD_BEEF) begin
      failures++;
      $display("FAIL load_wb: pulses=%0d dst=%0d data=%h want 1/5/deadbeef",
               obs_wb_cnt, obs_wb_dst, obs_wb_data);
    end
    checks++;
    if (obs_req_bad != 0 || obs_valid_cnt != 1 || obs_exc_cnt != 0) begin
      failures++;
      $display("FAIL load_req: bad=%0d valid_cycles=%0d exc=%0d want 0/1/0",
               obs_req_bad, obs_valid_cnt, obs_exc_cnt);
    end
  endtask

  task automatic test_store_backpressure();
    drive_txn(0, 64'h1000, {$urandom, $urandom}, 5'($urandom_range(0, 31)), 4, 1, 0,
              {$urandom, $urandom}, -1, -1, -1, 1);
    checks++;
    if (obs_valid_cnt != 5 || obs_req_bad != 0) begin
      failures++;
      $display("FAIL store_req_hold: valid_cycles=%0d unstable=%0d want 5/0",
               obs_valid_cnt, obs_req_bad);
    end
    checks++;
    if (!obs_done || obs_stall_cnt != 7 || obs_res_cyc != 7 || obs_wb_cnt != 0) begin
      failures++;
      $display("FAIL store_done: done=%0d stall=%0d result_cycle=%0d wb=%0d want 1/7/7/0",
               obs_done, obs_stall_cnt, obs_res_cyc, obs_wb_cnt);
    end
  endtask

  task automatic test_load_error();
    int r, d;
    r = $urandom_range(0, 2);
    d = $urandom_range(1, 2);
    drive_txn(1, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 31)), r, d, 1,
              {$urandom, $urandom}, -1, -1, -1, 1);
    checks++;
    if (obs_exc_cnt != 1 || obs_exc_store !== 1'b0 || obs_exc_cyc != 2 + r + d) begin
      failures++;
      $display("FAIL load_err_exc: pulses=%0d is_store=%0d cycle=%0d want 1/0/%0d",
               obs_exc_cnt, obs_exc_store, obs_exc_cyc, 2 + r + d);
    end
    checks++;
    if (obs_wb_cnt != 0 || obs_stall_cnt != 2 + r + d) begin
      failures++;
      $display("FAIL load_err_wb: wb=%0d stall=%0d want 0/%0d", obs_wb_cnt, obs_stall_cnt, 2 + r + d);
    end
  endtask

  task automatic test_timeout();
    drive_txn(1, {$urandom, $urandom}, {$urandom, $urandom}, 5'd9, 0, -1, 0,
              '0, -1, -1, TMO + 3, 4);
    checks++;
    if (!obs_done || obs_exc_cnt != 1 || obs_exc_cyc != TMO + 1 || obs_exc_store !== 1'b0) begin
      failures++;
      $display("FAIL timeout_exc: done=%0d pulses=%0d cycle=%0d is_store=%0d want 1/1/%0d/0",
               obs_done, obs_exc_cnt, obs_exc_cyc, obs_exc_store, TMO + 1);
    end
    checks++;
    if (obs_stall_cnt != TMO + 1 || obs_wb_cnt != 0 || obs_valid_cnt != 1) begin
      failures++;
      $display("FAIL timeout_stray: stall=%0d wb=%0d valid_cycles=%0d want %0d/0/1",
               obs_stall_cnt, obs_wb_cnt, obs_valid_cnt, TMO + 1);
    end
  endtask

  task automatic test_flush();
    logic [63:0] data;
    @(negedge clk);
    exe_valid = 1; ctrl = 16'h000C; flush = 1; mem_rsp_valid = 0; mem_req_ready = 0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_stall: got %b want 0", stall);
    end
    @(negedge clk);
    exe_valid = 0; flush = 0;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_capture: req=%b stall=%b want 0/0", mem_req_valid, stall);
    end
    drive_txn(1, {$urandom, $urandom}, '0, 5'd7, 0, 3, 0, {$urandom, $urandom}, 2, -1, -1, 1);
    checks++;
    if (!obs_done || obs_stall_cnt != 5 || obs_res_cyc != 5 || obs_wb_cnt != 0 || obs_exc_cnt != 0) begin
      failures++;
      $display("FAIL flush_wait: done=%0d stall=%0d result_cycle=%0d wb=%0d exc=%0d want 1/5/5/0/0",
               obs_done, obs_stall_cnt, obs_res_cyc, obs_wb_cnt, obs_exc_cnt);
    end
    data = {$urandom, $urandom};
    drive_txn(1, {$urandom, $urandom}, '0, 5'd12, 1, 2, 0, data, -1, -1, -1, 0);
    checks++;
    if (obs_wb_cnt != 1 || obs_wb_data !== data || obs_wb_dst !== 5'd12 || obs_stall_cnt != 5) begin
      failures++;
      $display("FAIL flush_next_load: wb=%0d data=%h dst=%0d stall=%0d want 1/%h/12/5",
               obs_wb_cnt, obs_wb_data, obs_wb_dst, obs_stall_cnt, data);
    end
  endtask

  task automatic test_reset_mid();
    drive_txn(1, {$urandom, $urandom}, '0, 5'd3, 0, 5, 0, {$urandom, $urandom}, -1, 3, -1, 1);
    checks++;
    if (obs_post_rst_bad || obs_stall_cnt != 4 || obs_wb_cnt != 0 || obs_exc_cnt != 0) begin
      failures++;
      $display("FAIL reset_mid: outputs_live=%0d stall=%0d wb=%0d exc=%0d want 0/4/0/0",
               obs_post_rst_bad, obs_stall_cnt, obs_wb_cnt, obs_exc_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] data;
    logic [4:0]  dst;
    for (int i = 0; i < 3; i++) begin
      data = {$urandom, $urandom};
      dst  = 5'($urandom_range(0, 31));
      drive_txn(1, {$urandom, $urandom}, '0, dst, 0, 1, 0, data, -1, -1, -1, 0);
      checks++;
      if (!obs_done || obs_wb_cnt != 1 || obs_wb_data !== data || obs_wb_dst !== dst ||
          obs_stall_cnt != 3) begin
        failures++;
        $display("FAIL back_to_back[%0d]: wb=%0d data=%h dst=%0d stall=%0d want 1/%h/%0d/3",
                 i, obs_wb_cnt, obs_wb_data, obs_wb_dst, obs_stall_cnt, data, dst);
      end
    end
  endtask

  task automatic test_random();
    bit          ld, er;
    int          r, d, lat;
    logic [63:0] addr, wdata, data;
    logic [4:0]  dst;
    for (int i = 0; i < 40; i++) begin
      ld = 1'($urandom_range(0, 1));
      er = ($urandom_range(0, 4) == 0);
      r  = $urandom_range(0, 3);
      d  = $urandom_range(1, 3);
      addr = {$urandom, $urandom}; wdata = {$urandom, $urandom}; data = {$urandom, $urandom};
      dst  = 5'($urandom_range(0, 31));
      lat  = 2 + r + d;
      drive_txn(ld, addr, wdata, dst, r, d, er, data, -1, -1, -1, $urandom_range(0, 1));
      checks++;
      if (!obs_done || obs_stall_cnt != lat || obs_res_cyc != lat || obs_valid_cnt != r + 1 ||
          obs_req_bad != 0) begin
        failures++;
        $display("FAIL rand_timing[%0d]: done=%0d stall=%0d res=%0d valid=%0d bad=%0d want 1/%0d/%0d/%0d/0",
                 i, obs_done, obs_stall_cnt, obs_res_cyc, obs_valid_cnt, obs_req_bad, lat, lat, r + 1);
      end
      checks++;
      if (obs_wb_cnt != int'(ld && !er) || obs_exc_cnt != int'(er) ||
          obs_exc_store !== (er && !ld) ||
          (ld && !er && (obs_wb_data !== data || obs_wb_dst !== dst))) begin
        failures++;
        $display("FAIL rand_result[%0d]: wb=%0d exc=%0d st=%0d data=%h dst=%0d want %0d/%0d/%0d/%h/%0d",
                 i, obs_wb_cnt, obs_exc_cnt, obs_exc_store, obs_wb_data, obs_wb_dst,
                 int'(ld && !er), int'(er), int'(er && !ld), data, dst);
      end
    end
  endtask

  initial begin
    test_reset();
    test_non_mem();
    test_load_basic();
    test_store_backpressure();
    test_load_error();
    test_timeout();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    @(negedge clk);
    exe_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exe_mem_stall_ctrl.md
Name: exe_mem_stall_ctrl

Overview:
Sequences load/store operations held in the EXE stage against a valid/ready memory port. It freezes the front of the pipeline (IF/ID/RR/EXE) while the access is outstanding, then releases the result to WB and the bypass network. Because the front pipeline is frozen, no load-use stall is needed upstream. It also handles flush, response timeout and access-fault reporting.

Parameters:
DATA_W, 64, width of address, store data and load data
TIMEOUT, 255, max cycles in REQ+WAIT before fault (counter width = clog2(TIMEOUT+1))

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
EXE_VALID  in  1  valid instruction in EXE
EXE_Control_Signal  in  16  EXE decode bundle; bit2=memory op, bit3=load (1) / store (0)
EXE_ADDR  in  DATA_W  effective address
EXE_STORE_DATA  in  DATA_W  store data
EXE_DST_FIELD  in  5  destination register
FLUSH  in  1  kill younger-than-commit work
MEM_REQ_VALID  out  1  request valid
MEM_REQ_READY  in  1  memory accepts request
MEM_REQ_ADDR  out  DATA_W  request address
MEM_REQ_WDATA  out  DATA_W  store data
MEM_REQ_WE  out  1  1=store
MEM_RSP_VALID  in  1  response (load data or store ack)
MEM_RSP_DATA  in  DATA_W  load data
MEM_RSP_ERR  in  1  bus error with response
STALL_PIPELINE  out  1  freeze IF..EXE
WB_VALID  out  1  load result valid (1 cycle)
WB_DST  out  5  load destination
WB_DATA  out  DATA_W  load result
EXC_VALID  out  1  access fault (1 cycle)
EXC_IS_STORE  out  1  fault was a store

Behaviour:
- States: IDLE, REQ, WAIT, DONE, DRAIN, FAULT. After reset: IDLE, counter 0, all outputs 0.
- Mem op detected = EXE_VALID & ctrl[2] & ~FLUSH.
- IDLE: STALL_PIPELINE is combinational and asserts in the same cycle a mem op is detected. Capture addr/wdata/we/dst and go to REQ. If RR/EXE hold a non-mem instruction, there is no stall.
- REQ: MEM_REQ_VALID=1 from registered copies. Address, data and we stay stable until MEM_REQ_READY. On handshake go to WAIT. STALL=1.
- WAIT: STALL=1, MEM_REQ_VALID=0. On MEM_RSP_VALID with ERR=0: latch data, go to DONE. With ERR=1: go to FAULT. A response arriving in the same cycle as the handshake is not legal; the memory returns it at least 1 cycle later.
- DONE (1 cycle): STALL=0 so the pipeline advances at the end of the cycle. WB_VALID=1 for loads only; stores produce no WB. The instruction still in EXE is not re-captured. Next state is IDLE.
- Minimum latency with zero-wait memory: detect cycle, REQ, WAIT, DONE = 4 cycles, stall high for 3.
- FAULT (1 cycle): EXC_VALID=1 and EXC_IS_STORE=we. STALL=0, no WB. Next state is IDLE.
- Timeout: the counter increments in REQ and WAIT and clears on entering IDLE. Reaching TIMEOUT means FAULT. A late response after a timeout is ignored in IDLE.
- FLUSH in IDLE: no capture.
- FLUSH in REQ: the request is not withdrawn. Keep VALID until handshake, then go to DRAIN.
- FLUSH in WAIT: go to DRAIN. If RSP_VALID arrives in the same cycle, discard it and go to IDLE.
- DRAIN: STALL=1. Consume one response, discard data and error, then go to IDLE. The timeout applies; on expiry go to IDLE with no EXC.
- FLUSH in DONE/FAULT: suppress WB_VALID/EXC_VALID. Next state is IDLE.
- RST mid-operation: return to IDLE immediately, with VALID/STALL/WB/EXC low the next cycle.

Decomposition:
- Shared package holds: state enum (3-bit), control-bundle bit indices (MEM_OP_BIT=2, LOAD_BIT=3), DATA_W default.
- One sub-module: mem_timeout_ctr (clear, enable, expired flag).

Test Plan:
- Load, READY=1, RSP after 1 cycle with 0xDEAD_BEEF, dst=5 -> STALL high 3 cycles; WB_VALID 1 cycle with WB_DST=5, WB_DATA=0xDEADBEEF; MEM_REQ_WE=0.
- Store addr=0x1000, READY low 4 cycles -> VALID/ADDR/WDATA stable all 4 cycles; no WB_VALID after ack; STALL drops in DONE.
- Load with RSP_ERR=1 -> EXC_VALID=1, EXC_IS_STORE=0 for one cycle; no WB_VALID.
- TIMEOUT=8, no response -> FAULT reached exactly 8 cycles after entering REQ; EXC_VALID pulses; a later stray RSP is ignored.
- FLUSH during WAIT, response 2 cycles later -> no WB_VALID; STALL stays 1 until the response, then back to IDLE; the next load proceeds normally.
- RST asserted in WAIT -> next cycle IDLE with all outputs 0; back-to-back loads after reset each complete with correct data.
